// File: rtl/jtag_dbg_pkg.sv
// Shared definitions for the JTAG/VIO register bridge: FSM states,
// status-word bit positions and default parameter values.
package jtag_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    BURST   = 2'd2
  } state_t;

  localparam int STAT_ERR_TIMEOUT = 0;
  localparam int STAT_ERR_ADDR    = 1;
  localparam int STAT_ERR_BUSY    = 2;
  localparam int STAT_FIFO_EMPTY  = 3;
  localparam int STAT_BUSY        = 4;
  localparam int STAT_CNT_LSB     = 8;

  localparam int DEF_AW          = 8;
  localparam int DEF_DW          = 16;
  localparam int DEF_NREG        = 8;
  localparam int DEF_RD_OFFSET   = 32;
  localparam int DEF_BUF_DEPTH   = 16;
  localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a VIO command level: one-cycle delayed copy,
// edge = level high while the delayed copy is still low.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/jtag_reg_bridge.sv
// VIO-to-register bridge: edge-triggered register writes with ack timeout,
// decoded read-back, and burst capture of a FWFT FIFO into a local buffer.
module jtag_reg_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int NREG        = DEF_NREG,
  parameter int RD_OFFSET   = DEF_RD_OFFSET,
  parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               reg_clk,
  input  logic               rst,
  input  logic [AW-1:0]      dbg_addr,
  input  logic [DW-1:0]      dbg_wdata,
  input  logic               dbg_wr,
  input  logic               dbg_rd,
  input  logic               dbg_fifo_rd,
  input  logic               dbg_clr,
  input  logic [7:0]         dbg_burst_len,
  output logic [DW-1:0]      dbg_rdata,
  output logic [15:0]        dbg_status,
  output logic [AW-1:0]      reg_wr_addr,
  output logic [DW-1:0]      reg_wr_data,
  output logic               reg_wr_en,
  input  logic               reg_wr_ack,
  input  logic [NREG*DW-1:0] reg_rd_data,
  input  logic [DW-1:0]      fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd
);

  localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic          wr_edge, rd_edge, fifo_edge, clr_edge;
  state_t        state;
  logic [CW-1:0] buf_cnt;
  logic [TW-1:0] tcnt;
  logic          err_busy, err_addr, err_timeout;
  logic [DW-1:0] buf_mem [BUF_DEPTH];
  logic [DW-1:0] rd_val;
  logic          rd_bad;
  logic          busy, pop, timeout_hit;
  logic          set_busy, set_addr, set_timeout;

  edge_det u_wr_edge   (.clk(reg_clk), .rst(rst), .level(dbg_wr),      .rise(wr_edge));
  edge_det u_rd_edge   (.clk(reg_clk), .rst(rst), .level(dbg_rd),      .rise(rd_edge));
  edge_det u_fifo_edge (.clk(reg_clk), .rst(rst), .level(dbg_fifo_rd), .rise(fifo_edge));
  edge_det u_clr_edge  (.clk(reg_clk), .rst(rst), .level(dbg_clr),     .rise(clr_edge));

  assign busy        = (state != IDLE);
  assign pop         = (state == BURST) && !fifo_empty &&
                       (32'(buf_cnt) < 32'(dbg_burst_len)) &&
                       (32'(buf_cnt) < 32'(BUF_DEPTH));
  assign timeout_hit = (state == WR_WAIT) && (32'(tcnt) + 32'd1 == 32'(ACK_TIMEOUT));
  assign fifo_rd     = pop;

  // Lower-priority edges colliding in IDLE are dropped just like edges while busy.
  assign set_busy    = busy ? (wr_edge | rd_edge | fifo_edge)
                            : ((wr_edge & (rd_edge | fifo_edge)) | (rd_edge & fifo_edge));
  assign set_addr    = !busy && rd_edge && !wr_edge && rd_bad;
  assign set_timeout = timeout_hit && !reg_wr_ack;

  always_comb begin
    rd_val = '0;
    rd_bad = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (32'(dbg_addr) == 32'(i)) begin
        rd_val = reg_rd_data[i*DW +: DW];
        rd_bad = 1'b0;
      end
    end
    if ((32'(dbg_addr) >= 32'(RD_OFFSET)) && (32'(dbg_addr) < 32'(RD_OFFSET + BUF_DEPTH))) begin
      rd_val = buf_mem[BW'(32'(dbg_addr) - 32'(RD_OFFSET))];
      rd_bad = 1'b0;
    end
  end

  always_ff @(posedge reg_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      buf_cnt     <= '0;
      tcnt        <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      dbg_rdata   <= '0;
      err_busy    <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      err_busy    <= (err_busy    & ~clr_edge) | set_busy;
      err_addr    <= (err_addr    & ~clr_edge) | set_addr;
      err_timeout <= (err_timeout & ~clr_edge) | set_timeout;
      case (state)
        IDLE: begin
          if (wr_edge) begin
            reg_wr_addr <= dbg_addr;
            reg_wr_data <= dbg_wdata;
            reg_wr_en   <= 1'b1;
            tcnt        <= '0;
            state       <= (ACK_TIMEOUT == 0) ? IDLE : WR_WAIT;
          end else if (rd_edge) begin
            dbg_rdata <= rd_val;
          end else if (fifo_edge) begin
            buf_cnt <= '0;
            state   <= BURST;
          end
        end
        // An ack arriving on the final counted cycle still counts as success.
        WR_WAIT: begin
          if (reg_wr_ack || timeout_hit) state <= IDLE;
          else                           tcnt  <= tcnt + 1'b1;
        end
        BURST: begin
          if (pop) buf_cnt <= buf_cnt + 1'b1;
          else     state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge reg_clk) begin
    if (pop) buf_mem[buf_cnt[BW-1:0]] <= fifo_data;
  end

  assign dbg_status = {8'(buf_cnt), 3'b000, busy, fifo_empty, err_busy, err_addr, err_timeout};

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Self-checking bench for jtag_reg_bridge: queue-based scoreboard for writes
// and reads, behavioural FWFT FIFO model, collisions and reset abort.
module tb_jtag_reg_bridge;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NREG = 8;

  localparam int CMD_WR   = 1;
  localparam int CMD_RD   = 2;
  localparam int CMD_FIFO = 4;
  localparam int CMD_CLR  = 8;

  logic               reg_clk = 1'b0;
  logic               rst = 1'b1;
  logic [AW-1:0]      dbg_addr = '0;
  logic [DW-1:0]      dbg_wdata = '0;
  logic               dbg_wr = 1'b0, dbg_rd = 1'b0, dbg_fifo_rd = 1'b0, dbg_clr = 1'b0;
  logic [7:0]         dbg_burst_len = '0;
  logic [DW-1:0]      dbg_rdata;
  logic [15:0]        dbg_status;
  logic [AW-1:0]      reg_wr_addr;
  logic [DW-1:0]      reg_wr_data;
  logic               reg_wr_en;
  logic               reg_wr_ack = 1'b0;
  logic [NREG*DW-1:0] reg_rd_data = '0;
  logic [DW-1:0]      fifo_data = '0;
  logic               fifo_empty = 1'b1;
  logic               fifo_rd;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int wr_pulses = 0;
  int pops_before;
  int fifo_size_before;
  logic [DW-1:0] fifo_q[$];
  logic [AW+DW-1:0] wr_exp_q[$];
  logic [DW-1:0] rd_exp_q[$];

  jtag_reg_bridge #(.ACK_TIMEOUT(4)) dut (
    .reg_clk(reg_clk), .rst(rst),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_fifo_rd(dbg_fifo_rd), .dbg_clr(dbg_clr),
    .dbg_burst_len(dbg_burst_len), .dbg_rdata(dbg_rdata), .dbg_status(dbg_status),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_wr_ack(reg_wr_ack), .reg_rd_data(reg_rd_data),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // FWFT FIFO model: head word is visible before the pop.
  always @(posedge reg_clk) begin
    if (fifo_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops <= pops + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
    fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Write scoreboard: every reg_wr_en pulse must match the oldest expected write.
  always @(negedge reg_clk) begin
    if (reg_wr_en) begin
      wr_pulses <= wr_pulses + 1;
      if (wr_exp_q.size() == 0) begin
        checkOutput("wr_unexpected", 32'(reg_wr_en), 32'd0);
      end else begin
        logic [AW+DW-1:0] e;
        e = wr_exp_q.pop_front();
        checkOutput("wr_addr", 32'(reg_wr_addr), 32'(e[AW+DW-1:DW]));
        checkOutput("wr_data", 32'(reg_wr_data), 32'(e[DW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic applyStimulus(input int cmd);
    dbg_wr      = cmd[0];
    dbg_rd      = cmd[1];
    dbg_fifo_rd = cmd[2];
    dbg_clr     = cmd[3];
    tick();
    dbg_wr = 1'b0; dbg_rd = 1'b0; dbg_fifo_rd = 1'b0; dbg_clr = 1'b0;
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
    logic [DW-1:0] e;
    dbg_addr = addr;
    rd_exp_q.push_back(exp);
    applyStimulus(CMD_RD);
    e = rd_exp_q.pop_front();
    checkOutput(tag, 32'(dbg_rdata), 32'(e));
    tick();
  endtask

  task automatic waitIdle(input int max_cycles, input string tag);
    int n = 0;
    while (dbg_status[4] && n < max_cycles) begin
      tick();
      n++;
    end
    if (dbg_status[4]) checkOutput(tag, 32'(dbg_status[4]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) reg_rd_data[i*DW +: DW] = 16'h1000 + 16'(i);
    reg_rd_data[3*DW +: DW] = 16'h1234;
    tick(); tick();
    checkOutput("rst_status", 32'(dbg_status), 32'h0008);
    checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rst_rdata", 32'(dbg_rdata), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] write with ack");
    dbg_addr = 8'h05; dbg_wdata = 16'hBEEF;
    wr_exp_q.push_back({8'h05, 16'hBEEF});
    applyStimulus(CMD_WR);
    checkOutput("wr_en_pulse", 32'(reg_wr_en), 32'd1);
    tick();
    checkOutput("wr_en_single", 32'(reg_wr_en), 32'd0);
    tick();
    checkOutput("wr_wait_busy", 32'(dbg_status[4]), 32'd1);
    reg_wr_ack = 1'b1; tick(); reg_wr_ack = 1'b0;
    checkOutput("wr_ack_idle", 32'(dbg_status[4]), 32'd0);
    checkOutput("wr_no_timeout", 32'(dbg_status[0]), 32'd0);

    $display("[TB] write timeout");
    dbg_addr = 8'h07; dbg_wdata = 16'h1111;
    wr_exp_q.push_back({8'h07, 16'h1111});
    applyStimulus(CMD_WR);
    tick(); tick(); tick();
    checkOutput("to_busy_3", 32'(dbg_status[4]), 32'd1);
    tick();
    checkOutput("to_idle_4", 32'(dbg_status[4]), 32'd0);
    checkOutput("to_flag", 32'(dbg_status[0]), 32'd1);
    applyStimulus(CMD_CLR);
    checkOutput("to_clr", 32'(dbg_status[0]), 32'd0);

    $display("[TB] ack on last counted cycle");
    dbg_addr = 8'h02; dbg_wdata = 16'h2222;
    wr_exp_q.push_back({8'h02, 16'h2222});
    applyStimulus(CMD_WR);
    tick(); tick(); tick();
    reg_wr_ack = 1'b1; tick(); reg_wr_ack = 1'b0;
    checkOutput("ack_edge_idle", 32'(dbg_status[4]), 32'd0);
    checkOutput("ack_edge_no_to", 32'(dbg_status[0]), 32'd0);

    $display("[TB] register reads");
    doRead(8'h03, 16'h1234, "rd_reg3");
    checkOutput("rd_reg3_noerr", 32'(dbg_status[1]), 32'd0);
    doRead(8'h07, 16'h1007, "rd_reg7");
    doRead(8'h10, 16'h0000, "rd_0x10");
    checkOutput("rd_0x10_err", 32'(dbg_status[1]), 32'd1);
    applyStimulus(CMD_CLR);
    doRead(8'h08, 16'h0000, "rd_0x08");
    checkOutput("rd_0x08_err", 32'(dbg_status[1]), 32'd1);
    applyStimulus(CMD_CLR);

    $display("[TB] short burst");
    for (int i = 0; i < 5; i++) fifo_q.push_back(16'hA0 + 16'(i));
    tick();
    dbg_burst_len = 8'd8;
    pops_before = pops;
    applyStimulus(CMD_FIFO);
    waitIdle(40, "burst5_hang");
    checkOutput("burst5_pops", 32'(pops - pops_before), 32'd5);
    checkOutput("burst5_cnt", 32'(dbg_status[15:8]), 32'd5);
    doRead(8'd34, 16'h00A2, "burst5_rd34");
    doRead(8'd32, 16'h00A0, "burst5_rd32");
    doRead(8'd36, 16'h00A4, "burst5_rd36");

    $display("[TB] burst limited by buffer depth");
    for (int i = 0; i < 20; i++) fifo_q.push_back(16'h100 + 16'(i));
    tick();
    dbg_burst_len = 8'd255;
    pops_before = pops;
    applyStimulus(CMD_FIFO);
    waitIdle(60, "burst16_hang");
    checkOutput("burst16_pops", 32'(pops - pops_before), 32'd16);
    checkOutput("burst16_cnt", 32'(dbg_status[15:8]), 32'd16);
    checkOutput("burst16_left", 32'(fifo_q.size()), 32'd4);
    doRead(8'd47, 16'h010F, "burst16_rd47");
    doRead(8'd48, 16'h0000, "burst16_rd48");
    checkOutput("burst16_rd48_err", 32'(dbg_status[1]), 32'd1);
    applyStimulus(CMD_CLR);

    $display("[TB] zero-length burst");
    dbg_burst_len = 8'd0;
    pops_before = pops;
    applyStimulus(CMD_FIFO);
    checkOutput("len0_busy", 32'(dbg_status[4]), 32'd1);
    tick();
    checkOutput("len0_idle", 32'(dbg_status[4]), 32'd0);
    checkOutput("len0_pops", 32'(pops - pops_before), 32'd0);
    checkOutput("len0_cnt", 32'(dbg_status[15:8]), 32'd0);

    $display("[TB] read during burst");
    dbg_burst_len = 8'd3;
    pops_before = pops;
    applyStimulus(CMD_FIFO);
    dbg_addr = 8'h05;
    applyStimulus(CMD_RD);
    checkOutput("coll_err_busy", 32'(dbg_status[2]), 32'd1);
    checkOutput("coll_rdata_held", 32'(dbg_rdata), 32'd0);
    waitIdle(20, "coll_hang");
    checkOutput("coll_pops", 32'(pops - pops_before), 32'd3);
    checkOutput("coll_left", 32'(fifo_q.size()), 32'd1);
    applyStimulus(CMD_CLR);
    checkOutput("coll_clr", 32'(dbg_status[2]), 32'd0);

    $display("[TB] simultaneous write and read");
    dbg_addr = 8'h06; dbg_wdata = 16'h5A5A;
    wr_exp_q.push_back({8'h06, 16'h5A5A});
    applyStimulus(CMD_WR | CMD_RD);
    checkOutput("sim_wr_en", 32'(reg_wr_en), 32'd1);
    checkOutput("sim_err_busy", 32'(dbg_status[2]), 32'd1);
    checkOutput("sim_rdata_held", 32'(dbg_rdata), 32'd0);
    reg_wr_ack = 1'b1; tick(); reg_wr_ack = 1'b0;
    checkOutput("sim_idle", 32'(dbg_status[4]), 32'd0);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 9; i++) fifo_q.push_back(16'h300 + 16'(i));
    tick();
    dbg_burst_len = 8'd10;
    applyStimulus(CMD_FIFO);
    tick();
    checkOutput("rstb_popping", 32'(fifo_rd), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstb_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rstb_status", 32'(dbg_status), 32'h0000);
    checkOutput("rstb_rdata", 32'(dbg_rdata), 32'd0);
    tick(); tick();
    rst = 1'b0;
    fifo_size_before = fifo_q.size();
    tick(); tick(); tick();
    checkOutput("rstb_no_pops", 32'(fifo_q.size()), 32'(fifo_size_before));
    checkOutput("rstb_idle", 32'(dbg_status[4]), 32'd0);

    checkOutput("wr_pulse_count", 32'(wr_pulses), 32'd4);
    checkOutput("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
